mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and HI/LO register width.
REQ-002 The block SHALL have parameter ITER, default 32 (equal to WIDTH), meaning the number of iteration cycles per multiply or divide.
REQ-003 The block SHALL use a single clock and a synchronous active-high reset, with ports exactly as follows.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  request pulse, sampled only in IDLE
- op  input  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
- dataA  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
- dataB  input  WIDTH  multiplier / divisor
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse: HI/LO hold a new MULTU/DIVU result
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ITER, DONE.
REQ-005 In IDLE, start=1 with op=MULTU or op=DIVU SHALL latch dataA, dataB and op into internal registers, clear the iteration counter, and move to ITER.
REQ-006 In IDLE, start=1 with op=MTHI or op=MTLO SHALL write dataA into hi or lo at that edge and stay in IDLE; busy and done SHALL stay 0.
REQ-007 busy SHALL be 1 in every cycle the FSM is in ITER, and 0 in all other states.
REQ-008 ITER SHALL last exactly ITER cycles; after the last iteration the FSM SHALL move to DONE.
REQ-009 The final hi/lo SHALL be written on the ITER-to-DONE edge.
REQ-010 done SHALL be 1 only in DONE, which lasts exactly one cycle; DONE SHALL then move to IDLE.
REQ-011 Latency: start sampled at edge T SHALL give busy=1 for cycles T+1..T+32, and done=1 with the result valid in cycle T+33.
REQ-012 MULTU SHALL be an unsigned shift-add operation, one multiplier bit per cycle, using a 2*WIDTH accumulator with carry kept (WIDTH+1-bit add); {hi,lo} SHALL equal the full unsigned product.
REQ-013 DIVU SHALL be an unsigned restoring division, one quotient bit per cycle, using a WIDTH+1-bit trial subtract; lo SHALL hold the quotient and hi the remainder.
REQ-014 DIVU with divisor 0 SHALL give lo=all ones and hi=dividend, with no exception and normal latency.
REQ-015 start SHALL be ignored in ITER and DONE; it SHALL neither queue nor abort.
REQ-016 hi/lo SHALL hold their previous values during ITER; intermediate state SHALL live only in internal registers.
REQ-017 Changes on dataA/dataB after the start edge SHALL NOT affect the result.

Reset
REQ-018 reset=1 at a clock edge SHALL force IDLE, hi=0, lo=0, busy=0, done=0, and clear the counter and internal registers.
REQ-019 Reset SHALL take priority over start and over any in-flight operation; an operation interrupted by reset SHALL be discarded and SHALL NOT produce a done pulse.

Structure
REQ-020 The shared package mdu_pkg SHALL hold the op encodings (MULTU, DIVU, MTHI, MTLO), the state encoding (IDLE, ITER, DONE) and the WIDTH default.
REQ-021 The block SHALL contain one sub-module, mdu_addsub: a combinational WIDTH+1-bit add/subtract step shared by the multiply and divide iterations, controlled by a sub input.
REQ-022 The iteration counter SHALL be 6 bits wide.

Verification
REQ-023 The bench SHALL run MULTU 6 x 7 -> done at T+33, hi=0x00000000, lo=0x0000002A, busy high for exactly 32 cycles.
REQ-024 The bench SHALL run MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-025 The bench SHALL run DIVU 100 / 7 -> lo=0x0000000E, hi=0x00000002; and DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=0x00000005.
REQ-026 The bench SHALL run MULTU 3 x 4, then pulse start with DIVU 9/3 at T+10 -> the second start is ignored, done occurs once at T+33, and lo=0x0000000C.
REQ-027 The bench SHALL run MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated the next cycle, busy=0 and done=0 throughout.
REQ-028 The bench SHALL start MULTU 2 x 2 and assert reset at T+10 -> the next cycle shows hi=lo=0, busy=0, no done pulse, and a new start is accepted immediately after reset deasserts.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default width.
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  // ST_ prefix keeps the state names clear of the unit's ITER parameter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/mdu_addsub.sv
// Combinational WIDTH+1-bit adder/subtractor shared by the multiply and divide steps.
// No latency, no flow control.
module mdu_addsub
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] y
);
  assign y = sub ? (a - b) : (a + b);
endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned MULTU/DIVU plus MTHI/MTLO moves into HI/LO.
// Result in HI/LO with done ITER+1 cycles after start; start is ignored while busy or done.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITER  = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_e           state;
  op_e              op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;

  logic             is_div;
  logic [WIDTH:0]   as_a;
  logic [WIDTH:0]   as_b;
  logic [WIDTH:0]   as_y;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  assign is_div = (op_r == OP_DIVU);

  // Multiply: acc_hi accumulates the multiplicand, acc_lo shifts out multiplier bits.
  // Divide: {acc_hi, acc_lo} is the remainder/dividend pair, quotient bits shift into acc_lo.
  always_comb begin
    as_a = is_div ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
    as_b = is_div ? {1'b0, b_r} : {1'b0, a_r};
  end

  mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (is_div),
    .y   (as_y)
  );

  always_comb begin
    mul_sum = acc_lo[0] ? as_y : {1'b0, acc_hi};
    if (is_div) begin
      // Bit WIDTH of the trial difference is the borrow: set means restore.
      nxt_hi = as_y[WIDTH] ? as_a[WIDTH-1:0] : as_y[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ~as_y[WIDTH]};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_r   <= OP_MULTU;
      a_r    <= '0;
      b_r    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op_e'(op))
              OP_MTHI: hi <= dataA;
              OP_MTLO: lo <= dataA;
              default: begin
                op_r   <= op_e'(op);
                a_r    <= dataA;
                b_r    <= dataB;
                acc_hi <= '0;
                acc_lo <= (op_e'(op) == OP_DIVU) ? dataA : dataB;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= ST_ITER;
              end
            endcase
          end
        end
        ST_ITER: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          if (cnt == CNT_W'(ITER - 1)) begin
            hi    <= nxt_hi;
            lo    <= nxt_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .ITER(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .dataA (dataA),
    .dataB (dataB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one MULTU/DIVU (releasing reset in the same cycle) and watches 40 cycles.
  // pulse_at > 0 fires an extra DIVU 9/3 start sampled at edge T+pulse_at.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int pulse_at, input string tag);
    logic [63:0] ref_v;
    int busy_cnt, busy_last, done_cyc, done_n;
    bit hold_ok;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; op = o; dataA = a; dataB = b;
    @(negedge clk);
    start = 1'b0; dataA = $urandom; dataB = $urandom;
    busy_cnt = 0; busy_last = 0; done_cyc = 0; done_n = 0; hold_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (busy) begin
        busy_cnt++;
        busy_last = k;
        if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
      end
      if (done) begin
        done_n++;
        done_cyc = k;
      end
      if (k == pulse_at - 1) begin
        start = 1'b1; op = OP_DIVU; dataA = 32'd9; dataB = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    if (o == OP_MULTU) ref_v = {32'b0, a} * {32'b0, b};
    else if (b == '0) ref_v = {a, 32'hFFFF_FFFF};
    else ref_v = {a % b, a / b};
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, " busy_last"}, 64'(busy_last), 64'd32);
    check({tag, " done_count"}, 64'(done_n), 64'd1);
    check({tag, " done_cycle"}, 64'(done_cyc), 64'd33);
    check({tag, " hilo_hold"}, 64'(hold_ok), 64'd1);
    check({tag, " hi_lo"}, {hi, lo}, ref_v);
    m_hi = ref_v[63:32];
    m_lo = ref_v[31:0];
  endtask

  initial begin
    bit quiet;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = '0; dataA = '0; dataB = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);

    do_op(OP_MULTU, 32'd6, 32'd7, 0, "mul 6x7");
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul max");
    do_op(OP_DIVU, 32'd100, 32'd7, 0, "div 100/7");
    do_op(OP_DIVU, 32'd5, 32'd0, 0, "div 5/0");
    do_op(OP_MULTU, 32'd3, 32'd4, 10, "mul 3x4 ignore start");

    // Register moves on consecutive cycles.
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; dataA = 32'h1234_5678;
    @(negedge clk);
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi busy_done", {62'b0, busy, done}, 64'd0);
    op = OP_MTLO; dataA = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", 64'(lo), 64'h9ABC_DEF0);
    check("mtlo hi", 64'(hi), 64'h1234_5678);
    check("mtlo busy_done", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    check("moves idle busy_done", {62'b0, busy, done}, 64'd0);
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;

    // Reset in the middle of a multiply discards it.
    start = 1'b1; op = OP_MULTU; dataA = 32'd2; dataB = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort busy_done", {62'b0, busy, done}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    quiet = 1'b1;
    repeat (36) begin
      @(negedge clk);
      if (busy || done) quiet = 1'b0;
    end
    check("abort no done", 64'(quiet), 64'd1);
    reset = 1'b1;
    do_op(OP_MULTU, $urandom, $urandom, 0, "start after reset");

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      do_op(2'($urandom_range(0, 1)), ra, rb, 0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
